vliw_bundle_loader: RTL and testbench

Program loader sitting directly upstream of the VLIW processor's instruction memory. Accepts a stream of 32-bit instruction words over a valid/ready handshake and packs them into 320-bit, 10-slot bundles. Writes each completed bundle into instruction memory at consecutive word-aligned indices (0, 4, 8, …). Replaces bench-side `writeInst` calls with synthesizable boot/load logic.

---
 rtl/vliw_bundle_loader.sv | 174 +++++++++++++++++
 tb/tb_vliw_bundle_loader.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vliw_bundle_loader.sv
// ---------------------------------------------------------------------------
// vliw_bundle_loader
//
// Boot/program loader that sits in front of the VLIW instruction memory.
// A stream of 32-bit instruction words arrives over a valid/ready handshake.
// The words are packed, first arrival in the most significant slot, into
// SLOTS-wide bundles. Each completed bundle is written into instruction
// memory at BASE_ADDR, BASE_ADDR+ADDR_STEP, ... with a one-cycle wr_en strobe.
//
// Ports
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   start          : single-cycle pulse that opens a load session (IDLE/DONE)
//   in_valid       : in_word/in_last are valid this cycle
//   in_ready       : loader accepts a word this cycle (high only while filling)
//   in_word        : instruction word
//   in_last        : marks the final word of the program
//   wr_en          : instruction-memory write strobe, one cycle per bundle
//   wr_bundle      : packed bundle data, held after the strobe
//   wr_addr        : bundle index, held after the strobe
//   busy           : session in progress
//   done           : session finished, held until the next start
//   err            : memory filled without seeing in_last, held until next start
//   bundle_count   : bundles written during the current session
// ---------------------------------------------------------------------------
module vliw_bundle_loader #(
   parameter int SLOTS       = 10,
   parameter int WORD_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int ADDR_STEP   = 4,
   parameter int BASE_ADDR   = 0,
   parameter int MAX_BUNDLES = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WORD_W-1:0]         in_word,
   input  logic                      in_last,
   output logic                      wr_en,
   output logic [SLOTS*WORD_W-1:0]   wr_bundle,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [7:0]                bundle_count
);

   localparam int                CNT_W       = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int                BUNDLE_W    = SLOTS * WORD_W;
   localparam logic [CNT_W-1:0]  LAST_SLOT   = CNT_W'(SLOTS - 1);
   localparam logic [7:0]        LAST_BUNDLE = 8'(MAX_BUNDLES - 1);
   localparam logic [ADDR_W-1:0] BASE        = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STEP        = ADDR_W'(ADDR_STEP);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE,
      DONE
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    slot;
   logic [BUNDLE_W-1:0] bundle;
   logic [BUNDLE_W-1:0] merged;
   logic [ADDR_W-1:0]   addr;
   logic                final_bundle;
   logic                accept;
   logic                closing;

   // in_ready is itself a registered output that is only high in FILL, so a
   // handshake can only complete while the loader is filling a bundle.
   assign accept  = in_valid & in_ready;

   // A bundle closes either when its last slot is filled or when the program
   // ends early; the unused lower slots then stay zero, which decodes as NOP.
   assign closing = (slot == LAST_SLOT) | in_last;

   // Bundle register with the incoming word dropped into the current slot.
   // Arrival order k lands at the k-th slot counted from the top of the
   // bundle, so the first word of a bundle occupies the most significant bits.
   always_comb begin
      merged = bundle;
      for (int s = 0; s < SLOTS; s++) begin
         if (slot == CNT_W'(s)) begin
            merged[(SLOTS-1-s)*WORD_W +: WORD_W] = in_word;
         end
      end
   end

   // Session controller. Every output is driven from here so all outputs are
   // registered. WRITE always lasts exactly one cycle, which gives the single
   // wr_en strobe and the one-cycle bubble per bundle on the input side.
   // The address and bundle counter advance on leaving WRITE, so wr_addr and
   // wr_bundle keep showing the bundle just written until the next one closes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         slot         <= '0;
         bundle       <= '0;
         addr         <= BASE;
         final_bundle <= 1'b0;
         in_ready     <= 1'b0;
         wr_en        <= 1'b0;
         wr_bundle    <= '0;
         wr_addr      <= BASE;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         bundle_count <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state        <= FILL;
                  slot         <= '0;
                  bundle       <= '0;
                  addr         <= BASE;
                  final_bundle <= 1'b0;
                  in_ready     <= 1'b1;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  err          <= 1'b0;
                  bundle_count <= '0;
               end
            end

            FILL: begin
               if (accept) begin
                  if (closing) begin
                     state        <= WRITE;
                     in_ready     <= 1'b0;
                     wr_en        <= 1'b1;
                     wr_bundle    <= merged;
                     wr_addr      <= addr;
                     final_bundle <= in_last;
                     slot         <= '0;
                     bundle       <= '0;
                  end else begin
                     bundle <= merged;
                     slot   <= slot + 1'b1;
                  end
               end
            end

            WRITE: begin
               wr_en        <= 1'b0;
               addr         <= addr + STEP;
               bundle_count <= bundle_count + 8'd1;
               if (final_bundle) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (bundle_count == LAST_BUNDLE) begin
                  // Memory is full and the program has not ended.
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end else begin
                  state    <= FILL;
                  in_ready <= 1'b1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vliw_bundle_loader.sv
// ---------------------------------------------------------------------------
// tb_vliw_bundle_loader
//
// Scoreboard bench for vliw_bundle_loader. Each session builds the list of
// bundles the program should produce by chunking the word list into groups
// of SLOTS words and pushes them into expQ; a monitor pops one entry on every
// wr_en and compares data and address. The DUT is built with a small memory
// capacity so the overflow path is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_vliw_bundle_loader;

   localparam int SLOTS     = 10;
   localparam int WORD_W    = 32;
   localparam int ADDR_W    = 32;
   localparam int ADDR_STEP = 4;
   localparam int BASE_ADDR = 0;
   localparam int MAXB      = 3;
   localparam int BW        = SLOTS * WORD_W;

   typedef struct packed {
      logic [BW-1:0]     bundle;
      logic [ADDR_W-1:0] addr;
   } exp_t;

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b0;
   logic              start    = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_last  = 1'b0;
   logic [WORD_W-1:0] in_word  = '0;
   logic              in_ready;
   logic              wr_en;
   logic [BW-1:0]     wr_bundle;
   logic [ADDR_W-1:0] wr_addr;
   logic              busy;
   logic              done;
   logic              err;
   logic [7:0]        bundle_count;

   exp_t              expQ[$];
   logic [WORD_W-1:0] progWords[$];
   logic [BW-1:0]     seenBundles[$];
   int                vectors     = 0;
   int                miscompares = 0;
   int                expCount    = 0;
   bit                expErr      = 1'b0;
   exp_t              monEntry;

   vliw_bundle_loader #(
      .SLOTS       (SLOTS),
      .WORD_W      (WORD_W),
      .ADDR_W      (ADDR_W),
      .ADDR_STEP   (ADDR_STEP),
      .BASE_ADDR   (BASE_ADDR),
      .MAX_BUNDLES (MAXB)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_word      (in_word),
      .in_last      (in_last),
      .wr_en        (wr_en),
      .wr_bundle    (wr_bundle),
      .wr_addr      (wr_addr),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .bundle_count (bundle_count)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   // Hang guard: a stuck run still reports and terminates.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [BW-1:0] act,
                              input logic [BW-1:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected bundle. After
   // the last expected write of a session, done must be up one cycle later.
   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_write", BW'(wr_addr), BW'(32'hFFFF_FFFF));
         end else begin
            monEntry = expQ.pop_front();
            seenBundles.push_back(wr_bundle);
            checkOutput("wr_bundle", wr_bundle, monEntry.bundle);
            checkOutput("wr_addr", BW'(wr_addr), BW'(monEntry.addr));
            checkOutput("in_ready_in_write", BW'(in_ready), BW'(1'b0));
            if (expQ.size() == 0) begin
               @(negedge clk);
               checkOutput("done_after_last_write", BW'(done), BW'(1'b1));
               checkOutput("wr_en_single_cycle", BW'(wr_en), BW'(1'b0));
            end
         end
      end
   end

   // Reference model: the program is cut into consecutive groups of SLOTS
   // words, the first word of a group at the top of the bundle, missing words
   // zero. Without in_last only MAXB full bundles fit and err is expected.
   function automatic int buildExpected(input bit withLast);
      int            n;
      int            nAccept;
      int            nb;
      logic [BW-1:0] b;
      exp_t          e;
      n       = progWords.size();
      nAccept = withLast ? n : MAXB * SLOTS;
      nb      = (nAccept + SLOTS - 1) / SLOTS;
      for (int i = 0; i < nb; i++) begin
         b = '0;
         for (int s = 0; s < SLOTS; s++) begin
            b = b << WORD_W;
            if (i * SLOTS + s < nAccept) b = b | BW'(progWords[i*SLOTS+s]);
         end
         e.bundle = b;
         e.addr   = ADDR_W'(BASE_ADDR + i * ADDR_STEP);
         expQ.push_back(e);
      end
      expCount = nb;
      expErr   = !withLast;
      return nAccept;
   endfunction

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_in_ready"}, BW'(in_ready), BW'(1'b0));
      checkOutput({tag, "_wr_en"}, BW'(wr_en), BW'(1'b0));
      checkOutput({tag, "_wr_bundle"}, wr_bundle, '0);
      checkOutput({tag, "_wr_addr"}, BW'(wr_addr), BW'(BASE_ADDR));
      checkOutput({tag, "_busy"}, BW'(busy), BW'(1'b0));
      checkOutput({tag, "_done"}, BW'(done), BW'(1'b0));
      checkOutput({tag, "_err"}, BW'(err), BW'(1'b0));
      checkOutput({tag, "_bundle_count"}, BW'(bundle_count), BW'(0));
   endtask

   // One-cycle start pulse; the session state is checked in the next cycle.
   // Returns one cycle after an active edge, ready for driveWords.
   task automatic startSession();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      checkOutput("start_in_ready", BW'(in_ready), BW'(1'b1));
      checkOutput("start_busy", BW'(busy), BW'(1'b1));
      checkOutput("start_done_clear", BW'(done), BW'(1'b0));
      checkOutput("start_err_clear", BW'(err), BW'(1'b0));
      checkOutput("start_bundle_count", BW'(bundle_count), BW'(0));
      @(posedge clk);
      #1;
   endtask

   // Offers words until nAccept handshakes complete. mode 0: continuous
   // valid, 1: valid toggling every cycle, 2: random valid. Idle cycles carry
   // garbage words and random in_last, which the loader must ignore.
   task automatic driveWords(input int nAccept, input bit withLast, input int mode,
                             input bit startNoise);
      int idx = 0;
      int cyc = 0;
      bit tog = 1'b0;
      bit v;
      bit acc;
      while (idx < nAccept && cyc < 1000) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = tog;
            default: v = 1'($urandom_range(0, 1));
         endcase
         tog      = !tog;
         in_valid = v;
         in_word  = v ? progWords[idx] : $urandom;
         in_last  = v ? (withLast && idx == progWords.size() - 1) : 1'($urandom_range(0, 1));
         start    = startNoise ? ($urandom_range(0, 3) == 0) : 1'b0;
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b0;
      checkOutput("words_accepted", BW'(idx), BW'(nAccept));
   endtask

   // One full session: model, start, drive, then the end-of-session state.
   task automatic applyStimulus(input bit withLast, input int mode, input bit startNoise);
      int nAccept;
      int leaks = 0;
      bit gotDone = 1'b0;
      seenBundles.delete();
      nAccept = buildExpected(withLast);
      startSession();
      driveWords(nAccept, withLast, mode, startNoise);
      if (!withLast) begin
         // Memory is full: surplus words must never be taken.
         for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_word  = progWords[nAccept];
            @(negedge clk);
            if (in_ready) leaks++;
         end
         in_valid = 1'b0;
         checkOutput("overflow_no_accept", BW'(leaks), BW'(0));
      end
      for (int c = 0; c < 60 && !gotDone; c++) begin
         @(negedge clk);
         gotDone = done;
      end
      checkOutput("session_done", BW'(done), BW'(1'b1));
      checkOutput("session_err", BW'(err), BW'(expErr));
      checkOutput("session_bundle_count", BW'(bundle_count), BW'(expCount));
      checkOutput("session_busy", BW'(busy), BW'(1'b0));
      checkOutput("session_in_ready", BW'(in_ready), BW'(1'b0));
      checkOutput("session_writes", BW'(seenBundles.size()), BW'(expCount));
      checkOutput("session_queue_drained", BW'(expQ.size()), BW'(0));
   endtask

   task automatic loadRandom(input int n);
      progWords.delete();
      for (int i = 0; i < n; i++) progWords.push_back($urandom);
   endtask

   task automatic loadSparse();
      progWords.delete();
      for (int i = 0; i < 30; i++) progWords.push_back(32'h0);
      progWords[2] = 32'h914001C3;
   endtask

   initial begin
      logic [BW-1:0] firstBundle;
      logic [WORD_W-1:0] topWord;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetValues("reset");
      rst_n = 1'b1;

      // Three full bundles, one non-zero word that must land at [255:224].
      loadSparse();
      applyStimulus(1'b1, 0, 1'b0);
      firstBundle = seenBundles[0];
      topWord     = firstBundle[255:224];
      checkOutput("bundle0_bits_255_224", BW'(topWord), BW'(32'h914001C3));

      // 13 words: second bundle holds three words then NOP padding.
      loadRandom(13);
      applyStimulus(1'b1, 0, 1'b0);

      // Same sparse program with a stalling producer.
      loadSparse();
      applyStimulus(1'b1, 1, 1'b0);

      // No in_last: memory fills after MAXB bundles and err is raised.
      loadRandom(MAXB * SLOTS + 5);
      applyStimulus(1'b0, 0, 1'b0);

      // Reset in the middle of a bundle: nothing written, outputs cleared.
      loadRandom(6);
      startSession();
      driveWords(6, 1'b0, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkResetValues("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      loadRandom(12);
      applyStimulus(1'b1, 2, 1'b0);

      // start pulses sprinkled over FILL and WRITE must be ignored.
      loadRandom(17);
      applyStimulus(1'b1, 2, 1'b1);

      // Random programs back to back, each started from DONE.
      for (int r = 0; r < 5; r++) begin
         loadRandom($urandom_range(1, MAXB * SLOTS));
         applyStimulus(1'b1, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
